frame_config_sequencer: RTL

Sequences configuration writes into a column-organised fabric of frame-configured tiles. Accepts a valid/ready stream of 32-bit configuration words, assembles one full frame's worth of row data, then drives the shared `FrameData` bus and a one-hot `FrameStrobe` for exactly one column and frame. It sits between the bitstream source (SPI/UART loader) and the fabric's `FrameData`/`FrameStrobe` column inputs.

---
 rtl/frame_cfg_pkg.sv | 43 ++++
 rtl/frame_strobe_decoder.sv | 41 ++++
 rtl/frame_config_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/frame_cfg_pkg.sv
// Shared types, header field layout and header check for the frame configuration sequencer.
// Shared by frame_config_sequencer and frame_strobe_decoder.
package frame_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_GAP    = 3'd4
    } seq_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam int HDR_SYNC_MSB  = 31;
    localparam int HDR_SYNC_LSB  = 24;
    localparam int HDR_COL_MSB   = 15;
    localparam int HDR_COL_LSB   = 8;
    localparam int HDR_FRAME_MSB = 4;
    localparam int HDR_FRAME_LSB = 0;

    localparam int HDR_COL_W   = HDR_COL_MSB - HDR_COL_LSB + 1;
    localparam int HDR_FRAME_W = HDR_FRAME_MSB - HDR_FRAME_LSB + 1;

    typedef struct packed {
        logic                   valid;
        logic [HDR_COL_W-1:0]   col;
        logic [HDR_FRAME_W-1:0] frame;
    } hdr_t;

    function automatic hdr_t check_header(input logic [31:0] word,
                                          input int unsigned num_cols,
                                          input int unsigned max_frames);
        hdr_t h;
        h.col   = word[HDR_COL_MSB:HDR_COL_LSB];
        h.frame = word[HDR_FRAME_MSB:HDR_FRAME_LSB];
        h.valid = (word[HDR_SYNC_MSB:HDR_SYNC_LSB] == SYNC_BYTE)
               && ({24'd0, h.col} < num_cols)
               && ({27'd0, h.frame} < max_frames);
        return h;
    endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// Registered one-hot decode of column/frame into the fabric FrameStrobe vector.
// Kept standalone so a readback controller can reuse it.
module frame_strobe_decoder
    import frame_cfg_pkg::*;
#(
    parameter int NumCols         = 4,
    parameter int MaxFramesPerCol = 20
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [HDR_COL_W-1:0]           col_i,
    input  logic [HDR_FRAME_W-1:0]         frame_i,
    input  logic                           en_i,
    output logic [NumCols*MaxFramesPerCol-1:0] strobe_o
);

    logic [NumCols*MaxFramesPerCol-1:0] strobe_d;
    logic [NumCols*MaxFramesPerCol-1:0] strobe_q;

    always_comb begin
        strobe_d = '0;
        for (int c = 0; c < NumCols; c++) begin
            for (int f = 0; f < MaxFramesPerCol; f++) begin
                strobe_d[c*MaxFramesPerCol + f] = en_i
                    && (col_i == HDR_COL_W'(c))
                    && (frame_i == HDR_FRAME_W'(f));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            strobe_q <= '0;
        end else begin
            strobe_q <= strobe_d;
        end
    end

    assign strobe_o = strobe_q;

endmodule

// File: rtl/frame_config_sequencer.sv
// Stream-to-frame configuration sequencer: header, NumRows data words, then one column/frame strobe.
// Optional build macro FRAME_COUNT_EN adds the 16-bit committed-frame counter and its port.
module frame_config_sequencer
    import frame_cfg_pkg::*;
#(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int NumRows         = 4,
    parameter int NumCols         = 4,
    parameter int StrobeCycles    = 1
) (
    input  logic                                CLK,
    input  logic                                reset,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [FrameBitsPerRow-1:0]          s_data,
    output logic [NumRows*FrameBitsPerRow-1:0]  FrameData,
    output logic [NumCols*MaxFramesPerCol-1:0]  FrameStrobe,
`ifdef FRAME_COUNT_EN
    output logic [15:0]                         frame_count,
`endif
    output logic                                busy,
    output logic                                err
);

    localparam int RW  = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int SCW = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
    localparam int DW  = NumRows * FrameBitsPerRow;

    seq_state_e             state_q, state_d;
    logic [RW-1:0]          row_q, row_d;
    logic [DW-1:0]          stage_q, stage_d;
    logic [DW-1:0]          frame_data_q, frame_data_d;
    logic [HDR_COL_W-1:0]   col_q, col_d;
    logic [HDR_FRAME_W-1:0] frame_q, frame_d;
    logic [SCW-1:0]         strb_cnt_q, strb_cnt_d;
    logic                   ready_q;
    logic                   busy_q;
    logic                   err_q, err_d;
    logic                   hs;
    hdr_t                   hdr;

    assign hs  = s_valid && ready_q;
    assign hdr = check_header(s_data, NumCols, MaxFramesPerCol);

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        stage_d      = stage_q;
        frame_data_d = frame_data_q;
        col_d        = col_q;
        frame_d      = frame_q;
        strb_cnt_d   = strb_cnt_q;
        err_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    if (hdr.valid) begin
                        col_d   = hdr.col;
                        frame_d = hdr.frame;
                        row_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (hs) begin
                    for (int r = 0; r < NumRows; r++) begin
                        if (row_q == RW'(r)) begin
                            stage_d[r*FrameBitsPerRow +: FrameBitsPerRow] = s_data;
                        end
                    end
                    if (row_q == RW'(NumRows - 1)) begin
                        // Commit includes the word accepted this cycle.
                        frame_data_d = stage_d;
                        state_d      = ST_SETUP;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                strb_cnt_d = SCW'(StrobeCycles - 1);
                state_d    = ST_STROBE;
            end
            ST_STROBE: begin
                if (strb_cnt_q == '0) begin
                    state_d = ST_GAP;
                end else begin
                    strb_cnt_d = strb_cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            stage_q      <= '0;
            frame_data_q <= '0;
            col_q        <= '0;
            frame_q      <= '0;
            strb_cnt_q   <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            stage_q      <= stage_d;
            frame_data_q <= frame_data_d;
            col_q        <= col_d;
            frame_q      <= frame_d;
            strb_cnt_q   <= strb_cnt_d;
            ready_q      <= (state_d == ST_IDLE) || (state_d == ST_DATA);
            busy_q       <= (state_d != ST_IDLE);
            err_q        <= err_d;
        end
    end

    // Decoder registers its output, so it is fed the next state to align with STROBE.
    frame_strobe_decoder #(
        .NumCols         (NumCols),
        .MaxFramesPerCol (MaxFramesPerCol)
    ) u_strobe_dec (
        .clk_i    (CLK),
        .reset_i  (reset),
        .col_i    (col_q),
        .frame_i  (frame_q),
        .en_i     (state_d == ST_STROBE),
        .strobe_o (FrameStrobe)
    );

`ifdef FRAME_COUNT_EN
    logic [15:0] frame_count_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            frame_count_q <= '0;
        end else if (state_q == ST_GAP) begin
            frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign frame_count = frame_count_q;
`endif

    assign s_ready   = ready_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign FrameData = frame_data_q;

endmodule
